// File: rtl/seg_hex_array.sv
// Multi-digit hex 7-segment driver: latches a packed value on iLOAD and presents
// decoded digits both in parallel and time-multiplexed with a one-hot digit select.
module seg_hex_array #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iVALUE,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic [NUM_DIGITS-1:0]   iBLINK_EN,
    input  logic                    iLZ_BLANK,
    input  logic                    iENABLE,
    output logic [7*NUM_DIGITS-1:0] oHEX,
    output logic [NUM_DIGITS-1:0]   oDP,
    output logic [6:0]              oSEG,
    output logic                    oSEG_DP,
    output logic [NUM_DIGITS-1:0]   oDIG_SEL,
    output logic                    oFRAME
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    // Reference patterns are active-low, bit order g..a.
    function automatic logic [6:0] decodeLow(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h18;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    logic [4*NUM_DIGITS-1:0] valReg;
    logic [NUM_DIGITS-1:0]   dpReg;
    logic [NUM_DIGITS-1:0]   blkReg;
    logic [DIV_W-1:0]        divCnt;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frameCnt;
    logic                    phase;
    logic                    wrapPulse;
    logic                    divTerm;
    logic                    idxWrap;
    logic [6:0]              segPat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dpPat;

    assign divTerm = (divCnt == DIV_W'(SCAN_DIV - 1));
    assign idxWrap = divTerm && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            valReg <= '0;
            dpReg  <= '0;
            blkReg <= '0;
        end else if (iLOAD) begin
            valReg <= iVALUE;
            dpReg  <= iDP;
            blkReg <= iBLINK_EN;
        end
    end

    // Scan divider, digit index and blink phase; wrapPulse lines oFRAME up with the first cycle of digit 0.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            divCnt    <= '0;
            idx       <= '0;
            frameCnt  <= '0;
            phase     <= 1'b0;
            wrapPulse <= 1'b0;
        end else begin
            wrapPulse <= idxWrap;
            if (divTerm) begin
                divCnt <= '0;
                idx    <= idxWrap ? '0 : idx + 1'b1;
            end else begin
                divCnt <= divCnt + 1'b1;
            end
            if (idxWrap) begin
                if (frameCnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frameCnt <= '0;
                    phase    <= ~phase;
                end else begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
        end
    end

    // Walk from the top digit down so allZero tracks "this digit and everything above is zero".
    always_comb begin : digitFormat
        logic       allZero;
        logic [6:0] seg;
        logic       dpBit;
        allZero = 1'b1;
        seg     = 7'h00;
        dpBit   = 1'b0;
        segPat  = '{default: SEG_OFF};
        dpPat   = {NUM_DIGITS{DP_OFF}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (valReg[4*k +: 4] == 4'h0);
            seg     = ~decodeLow(valReg[4*k +: 4]);
            dpBit   = dpReg[k];
            if (iLZ_BLANK && allZero && (k != 0)) begin
                seg = 7'h00;
            end
            if (!iENABLE || (phase && blkReg[k])) begin
                seg   = 7'h00;
                dpBit = 1'b0;
            end
            segPat[k] = ACTIVE_LOW ? ~seg : seg;
            dpPat[k]  = ACTIVE_LOW ? ~dpBit : dpBit;
        end
    end

    // Everything leaves through one register stage, so oSEG and oDIG_SEL always switch on the same edge.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oHEX     <= {NUM_DIGITS{SEG_OFF}};
            oDP      <= {NUM_DIGITS{DP_OFF}};
            oSEG     <= SEG_OFF;
            oSEG_DP  <= DP_OFF;
            oDIG_SEL <= '0;
            oFRAME   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                oHEX[7*k +: 7] <= segPat[k];
            end
            oDP      <= dpPat;
            oSEG     <= segPat[idx];
            oSEG_DP  <= dpPat[idx];
            oDIG_SEL <= NUM_DIGITS'(1) << idx;
            oFRAME   <= wrapPulse;
        end
    end

endmodule

// File: tb/tb_seg_hex_array.sv
// Self-checking bench for seg_hex_array: directed table, scan/blink sequences and
// random stimulus against a cycle-count based reference model, on both polarities.
module tb_seg_hex_array;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iLOAD;
    logic [15:0] iVALUE;
    logic [3:0]  iDP;
    logic [3:0]  iBLINK_EN;
    logic        iLZ_BLANK;
    logic        iENABLE;

    logic [27:0] hexLow,   hexHigh;
    logic [3:0]  dpLow,    dpHigh;
    logic [6:0]  segLow,   segHigh;
    logic        segDpLow, segDpHigh;
    logic [3:0]  selLow,   selHigh;
    logic        frameLow, frameHigh;

    int checkCount = 0;
    int passCount  = 0;
    bit modelOn    = 1'b0;

    always #5 iCLK = ~iCLK;

    seg_hex_array #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dutLow (
        .iCLK(iCLK), .iRST(iRST), .iLOAD(iLOAD), .iVALUE(iVALUE), .iDP(iDP),
        .iBLINK_EN(iBLINK_EN), .iLZ_BLANK(iLZ_BLANK), .iENABLE(iENABLE),
        .oHEX(hexLow), .oDP(dpLow), .oSEG(segLow), .oSEG_DP(segDpLow),
        .oDIG_SEL(selLow), .oFRAME(frameLow)
    );

    seg_hex_array #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dutHigh (
        .iCLK(iCLK), .iRST(iRST), .iLOAD(iLOAD), .iVALUE(iVALUE), .iDP(iDP),
        .iBLINK_EN(iBLINK_EN), .iLZ_BLANK(iLZ_BLANK), .iENABLE(iENABLE),
        .oHEX(hexHigh), .oDP(dpHigh), .oSEG(segHigh), .oSEG_DP(segDpHigh),
        .oDIG_SEL(selHigh), .oFRAME(frameHigh)
    );

    function automatic logic [6:0] codeLow(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Lit-segment view (1 = lit) of the whole display: {dp[3:0], hex[27:0]}.
    function automatic logic [31:0] modelDisplay(input logic [15:0] val, input logic [3:0] dpm,
                                                 input logic [3:0] blk, input logic lz,
                                                 input logic en, input logic ph);
        logic [31:0] r;
        logic [6:0]  seg;
        logic        dpk;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            seg = ~codeLow(val[4*k +: 4]);
            dpk = dpm[k];
            if (lz && k > 0 && (val >> (4 * k)) == 16'd0) seg = 7'h00;
            if (!en || (ph && blk[k])) begin
                seg = 7'h00;
                dpk = 1'b0;
            end
            r[7*k +: 7] = seg;
            r[28 + k]   = dpk;
        end
        return r;
    endfunction

    logic [15:0] mVal;
    logic [3:0]  mDp, mBlk;
    int          edgeCnt;
    int          modelIdx;
    logic        modelPhase;
    logic [31:0] modelNow;
    logic [27:0] expHex;
    logic [3:0]  expDp, expSel;
    logic [6:0]  expSeg;
    logic        expSegDp, expFrame;

    assign modelIdx   = (edgeCnt / SD) % ND;
    assign modelPhase = (((edgeCnt / FRAME) / BF) % 2) == 1;
    assign modelNow   = modelDisplay(mVal, mDp, mBlk, iLZ_BLANK, iENABLE, modelPhase);

    // Expected outputs after each edge, derived from the number of edges since reset release.
    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mVal     <= '0;
            mDp      <= '0;
            mBlk     <= '0;
            edgeCnt  <= 0;
            expHex   <= '0;
            expDp    <= '0;
            expSeg   <= '0;
            expSegDp <= 1'b0;
            expSel   <= '0;
            expFrame <= 1'b0;
        end else begin
            expHex   <= modelNow[27:0];
            expDp    <= modelNow[31:28];
            expSeg   <= modelNow[7*modelIdx +: 7];
            expSegDp <= modelNow[28 + modelIdx];
            expSel   <= 4'(1 << modelIdx);
            expFrame <= (edgeCnt > 0) && (edgeCnt % FRAME == 0);
            if (iLOAD) begin
                mVal <= iVALUE;
                mDp  <= iDP;
                mBlk <= iBLINK_EN;
            end
            edgeCnt <= edgeCnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp, input logic [3:0] blk,
                                 input logic lz, input logic en, input logic load);
        iVALUE    = value;
        iDP       = dp;
        iBLINK_EN = blk;
        iLZ_BLANK = lz;
        iENABLE   = en;
        iLOAD     = load;
    endtask

    always @(negedge iCLK) begin
        if (modelOn) begin
            checkOutput("model hexLow",    {4'h0, hexLow},  {4'h0, ~expHex});
            checkOutput("model dpLow",     {28'h0, dpLow},  {28'h0, ~expDp});
            checkOutput("model segLow",    {25'h0, segLow}, {25'h0, ~expSeg});
            checkOutput("model segDpLow",  {31'h0, segDpLow}, {31'h0, ~expSegDp});
            checkOutput("model hexHigh",   {4'h0, hexHigh}, {4'h0, expHex});
            checkOutput("model dpHigh",    {28'h0, dpHigh}, {28'h0, expDp});
            checkOutput("model segHigh",   {25'h0, segHigh}, {25'h0, expSeg});
            checkOutput("model segDpHigh", {31'h0, segDpHigh}, {31'h0, expSegDp});
            checkOutput("model sel",       {28'h0, selLow}, {28'h0, expSel});
            checkOutput("model selHigh",   {28'h0, selHigh}, {28'h0, expSel});
            checkOutput("model frame",     {31'h0, frameLow}, {31'h0, expFrame});
            checkOutput("model frameHigh", {31'h0, frameHigh}, {31'h0, expFrame});
        end
    end

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [27:0] expHex;
    } vecT;

    vecT vecs [19];

    initial begin
        logic [3:0]  selPrev;
        logic [15:0] rv;
        int          frames;

        vecs[0] = '{16'h89AB, 1'b0, {7'h00, 7'h18, 7'h08, 7'h03}};
        vecs[1] = '{16'h0040, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        for (int d = 0; d < 16; d++) begin
            vecs[3 + d] = '{16'(d), 1'b0, {7'h40, 7'h40, 7'h40, codeLow(4'(d))}};
        end

        iRST = 1'b1;
        applyStimulus(16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge iCLK);
        modelOn = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;

        applyStimulus(16'h5A5A, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge iCLK);
        iLOAD = 1'b0;
        repeat (6) @(negedge iCLK);

        // Asynchronous reset between edges must clear outputs without waiting for a clock.
        #2 iRST = 1'b1;
        #1;
        checkOutput("asyncRst hexLow", {4'h0, hexLow}, 32'h0FFF_FFFF);
        checkOutput("asyncRst dpLow", {28'h0, dpLow}, 32'hF);
        checkOutput("asyncRst segLow", {25'h0, segLow}, 32'h7F);
        checkOutput("asyncRst segDpLow", {31'h0, segDpLow}, 32'h1);
        checkOutput("asyncRst sel", {28'h0, selLow}, 32'h0);
        checkOutput("asyncRst frame", {31'h0, frameLow}, 32'h0);
        checkOutput("asyncRst hexHigh", {4'h0, hexHigh}, 32'h0);
        @(negedge iCLK);
        iRST = 1'b0;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].value, 4'h0, 4'h0, vecs[i].lz, 1'b1, 1'b1);
            @(negedge iCLK);
            iLOAD = 1'b0;
            @(negedge iCLK);
            checkOutput($sformatf("table[%0d] hexLow", i), {4'h0, hexLow}, {4'h0, vecs[i].expHex});
            checkOutput($sformatf("table[%0d] hexHigh", i), {4'h0, hexHigh}, {4'h0, ~vecs[i].expHex});
        end

        applyStimulus(16'h0123, 4'b0100, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge iCLK);
        iLOAD = 1'b0;
        @(negedge iCLK);
        checkOutput("dp digit2", {28'h0, dpLow}, 32'hB);
        checkOutput("enabled hex", {4'h0, hexLow}, {4'h0, 7'h40, 7'h79, 7'h24, 7'h30});
        iENABLE = 1'b0;
        @(negedge iCLK);
        checkOutput("disabled hex", {4'h0, hexLow}, 32'h0FFF_FFFF);
        checkOutput("disabled dp", {28'h0, dpLow}, 32'hF);
        checkOutput("disabled selOneHot", {31'h0, $onehot(selLow)}, 32'h1);
        selPrev = selLow;
        repeat (SD) @(negedge iCLK);
        checkOutput("disabled selMoves", {31'h0, selLow != selPrev}, 32'h1);
        iENABLE = 1'b1;
        @(negedge iCLK);
        checkOutput("reenabled hex", {4'h0, hexLow}, {4'h0, 7'h40, 7'h79, 7'h24, 7'h30});

        // Restart from reset so edge numbers line up with scan and blink boundaries.
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        applyStimulus(16'h1234, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b1);
        frames = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge iCLK);
            if (n == 1) iLOAD = 1'b0;
            if (frameLow) begin
                frames++;
                checkOutput($sformatf("frameSel n=%0d", n), {28'h0, selLow}, 32'h1);
            end
            case (n)
                4:  checkOutput("scan sel n=4", {28'h0, selLow}, 32'h1);
                5:  checkOutput("scan sel n=5", {28'h0, selLow}, 32'h2);
                9:  checkOutput("scan sel n=9", {28'h0, selLow}, 32'h4);
                13: checkOutput("scan sel n=13", {28'h0, selLow}, 32'h8);
                17: checkOutput("scan sel n=17", {28'h0, selLow}, 32'h1);
                10: checkOutput("blink visible n=10", {25'h0, hexLow[13:7]}, 32'h30);
                70: checkOutput("blink visible n=70", {25'h0, hexLow[13:7]}, 32'h30);
                100: checkOutput("blink off n=100", {25'h0, hexLow[13:7]}, 32'h7F);
                40: begin
                    checkOutput("blink off n=40", {25'h0, hexLow[13:7]}, 32'h7F);
                    checkOutput("blink other n=40", {25'h0, hexLow[6:0]}, 32'h19);
                end
                default: ;
            endcase
        end
        checkOutput("frame pulses", frames, 6);

        for (int i = 0; i < 600; i++) begin
            @(negedge iCLK);
            for (int k = 0; k < ND; k++) begin
                rv[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            applyStimulus(rv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 2) == 0));
        end
        @(negedge iCLK);
        modelOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
